ahb_bram_loader: RTL and testbench



---
 rtl/ahb_lite_pkg.sv | 30 +++
 rtl/bram_loader_byte_pack.sv | 52 +++++
 rtl/ahb_bram_loader.sv | 180 ++++++++++++++++++
 tb/tb_ahb_bram_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// -----------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings and the boot-loader state type.
//   HTRANS_*    : AHB transfer type encodings
//   HSIZE_WORD  : 32-bit transfer size
//   RSP_*       : single-bit HRESP values
//   loader_state_t : ahb_bram_loader FSM states
// -----------------------------------------------------------------------------
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HSIZE_WORD    = 2'b10;

    localparam logic       RSP_OKAY      = 1'b0;
    localparam logic       RSP_ERROR     = 1'b1;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_FILL = 3'd1,
        LD_ADDR = 3'd2,
        LD_DATA = 3'd3,
        LD_DONE = 3'd4,
        LD_ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/bram_loader_byte_pack.sv
// -----------------------------------------------------------------------------
// bram_loader_byte_pack
// Four-byte little-endian word assembler. The first accepted byte lands in
// [7:0], the fourth in [31:24]. Once four bytes are held, further accepts are
// ignored until i_clear.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_accept       : a byte is transferred this cycle
//   i_byte         : byte value
//   i_clear        : empty the assembler (takes priority over i_accept)
//   o_word         : assembled word (lanes above o_byte_cnt are stale)
//   o_full         : four bytes held
//   o_byte_cnt     : number of bytes held, 0..4
// -----------------------------------------------------------------------------
module bram_loader_byte_pack (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_full,
    output logic [2:0]  o_byte_cnt
);

    logic [2:0]  r_cnt;
    logic [31:0] r_word;
    logic        w_take;

    assign w_take = i_accept && !r_cnt[2] && !i_clear;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 3'd0;
        end else if (i_clear) begin
            r_cnt <= 3'd0;
        end else if (w_take) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Lanes need no reset: a word is only consumed once all four are written.
    always_ff @(posedge i_clk) begin
        if (w_take) begin
            r_word[8*r_cnt[1:0] +: 8] <= i_byte;
        end
    end

    assign o_word     = r_word;
    assign o_full     = r_cnt[2];
    assign o_byte_cnt = r_cnt;

endmodule

// File: rtl/ahb_bram_loader.sv
// -----------------------------------------------------------------------------
// ahb_bram_loader
// AHB-Lite write-only master that fills a 32-bit block RAM from a byte stream.
// Bytes are packed little-endian and written as single NONSEQ word transfers
// to consecutive addresses starting at BASE_ADDR (wrapping modulo the RAM).
//   HCLK, HRESET          : bus clock, asynchronous active-high reset
//   start, num_words      : begin a load of num_words words (0 = done at once)
//   s_valid/s_data/s_ready: byte stream handshake
//   HSELBRAM, HADDR, HTRANS, HSIZE, HWRITE, HWDATA : AHB master outputs
//   HREADY, HRESP         : AHB slave response
//   busy, done, error     : load status
// -----------------------------------------------------------------------------
module ahb_bram_loader
    import ahb_lite_pkg::*;
#(
    parameter int                       ADDRESSWIDTH = 14,
    parameter logic [ADDRESSWIDTH-1:0]  BASE_ADDR    = '0
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-2:0] num_words,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    output logic                    s_ready,
    output logic                    HSELBRAM,
    output logic [ADDRESSWIDTH-1:0] HADDR,
    output logic [1:0]              HTRANS,
    output logic [1:0]              HSIZE,
    output logic                    HWRITE,
    output logic [31:0]             HWDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [ADDRESSWIDTH-2:0] CNT_ONE     = 1;
    localparam logic [ADDRESSWIDTH-1:0] WORD_STRIDE = 4;

    loader_state_t             r_state;
    loader_state_t             w_state_nxt;
    logic [ADDRESSWIDTH-2:0]   r_num_words;
    logic [ADDRESSWIDTH-2:0]   r_word_cnt;
    logic [ADDRESSWIDTH-1:0]   r_haddr;
    logic [31:0]               r_hwdata;

    logic                      w_start_ld;
    logic                      w_clear;
    logic                      w_ld_hwdata;
    logic                      w_word_done;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_full_nxt;
    logic [31:0]               w_word;
    logic                      w_full;
    logic [2:0]                w_byte_cnt;

    bram_loader_byte_pack u_pack (
        .i_clk      (HCLK),
        .i_rst      (HRESET),
        .i_accept   (w_accept),
        .i_byte     (s_data),
        .i_clear    (w_clear),
        .o_word     (w_word),
        .o_full     (w_full),
        .o_byte_cnt (w_byte_cnt)
    );

    // The word in flight is the final one; no bytes are taken for a word that
    // will never be written, so the next image's first byte stays at the source.
    assign w_last = (r_word_cnt + CNT_ONE) == r_num_words;

    // s_ready depends only on registered state, never on s_valid or the bus.
    assign w_ready    = !w_full && ((r_state == LD_FILL) ||
                                    ((r_state == LD_DATA) && !w_last));
    assign s_ready    = w_ready;
    assign w_accept   = s_valid && w_ready;
    // Four bytes held after this edge: lets DATA/FILL go straight to ADDR
    // when the fourth byte arrives in the same cycle as the decision.
    assign w_full_nxt = w_full || (w_accept && (w_byte_cnt == 3'd3));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ld  = 1'b0;
        w_clear     = 1'b0;
        w_ld_hwdata = 1'b0;
        w_word_done = 1'b0;
        HTRANS      = HTRANS_IDLE;
        HSELBRAM    = 1'b0;
        HWRITE      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            LD_IDLE, LD_DONE, LD_ERR: begin
                done  = (r_state == LD_DONE);
                error = (r_state == LD_ERR);
                if (start) begin
                    w_start_ld  = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = (num_words == '0) ? LD_DONE : LD_FILL;
                end
            end
            LD_FILL: begin
                busy = 1'b1;
                if (w_full_nxt) begin
                    w_state_nxt = LD_ADDR;
                end
            end
            LD_ADDR: begin
                busy     = 1'b1;
                HTRANS   = HTRANS_NONSEQ;
                HSELBRAM = 1'b1;
                HWRITE   = 1'b1;
                if (HREADY) begin
                    w_ld_hwdata = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = LD_DATA;
                end
            end
            LD_DATA: begin
                busy = 1'b1;
                if (HRESP == RSP_ERROR) begin
                    w_state_nxt = LD_ERR;
                end else if (HREADY) begin
                    w_word_done = 1'b1;
                    if (w_last) begin
                        w_state_nxt = LD_DONE;
                    end else if (w_full_nxt) begin
                        w_state_nxt = LD_ADDR;
                    end else begin
                        w_state_nxt = LD_FILL;
                    end
                end
            end
            default: begin
                w_state_nxt = LD_IDLE;
            end
        endcase
    end

    // HADDR is kept as a running byte address so it wraps naturally.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_haddr     <= BASE_ADDR;
            r_hwdata    <= 32'd0;
        end else begin
            if (w_start_ld) begin
                r_num_words <= num_words;
                r_word_cnt  <= '0;
                r_haddr     <= BASE_ADDR;
            end
            if (w_word_done) begin
                r_word_cnt <= r_word_cnt + CNT_ONE;
                r_haddr    <= r_haddr + WORD_STRIDE;
            end
            if (w_ld_hwdata) begin
                r_hwdata <= w_word;
            end
        end
    end

    assign HADDR  = r_haddr;
    assign HSIZE  = HSIZE_WORD;
    assign HWDATA = r_hwdata;

endmodule

// File: tb/tb_ahb_bram_loader.sv
module tb_ahb_bram_loader;

    localparam int AW = 14;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          start, start_w;
    logic [AW-2:0] num_words, num_words_w;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          HREADY, HRESP;

    logic          s_ready, HSELBRAM, HWRITE, busy, done, error;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS, HSIZE;
    logic [31:0]   HWDATA;

    logic          s_ready_w, HSELBRAM_w, HWRITE_w, busy_w, done_w, error_w;
    logic [AW-1:0] HADDR_w;
    logic [1:0]    HTRANS_w, HSIZE_w;
    logic [31:0]   HWDATA_w;

    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    q[$];
    int            qi = 0;

    ahb_bram_loader #(.ADDRESSWIDTH(AW), .BASE_ADDR(14'h0000)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .HSELBRAM(HSELBRAM), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .busy(busy), .done(done), .error(error)
    );

    ahb_bram_loader #(.ADDRESSWIDTH(AW), .BASE_ADDR(14'h3FFC)) dut_w (
        .HCLK(HCLK), .HRESET(HRESET), .start(start_w), .num_words(num_words_w),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_w),
        .HSELBRAM(HSELBRAM_w), .HADDR(HADDR_w), .HTRANS(HTRANS_w), .HSIZE(HSIZE_w),
        .HWRITE(HWRITE_w), .HWDATA(HWDATA_w), .HREADY(HREADY), .HRESP(HRESP),
        .busy(busy_w), .done(done_w), .error(error_w)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        if (qi < q.size()) begin
            s_valid = 1'b1;
            s_data  = q[qi];
        end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
        end
    endtask

    // One clock; the byte source advances when the previous cycle handshook.
    task automatic tick();
        logic acc;
        acc = s_valid && (s_ready || s_ready_w);
        @(posedge HCLK);
        #1;
        if (acc) qi++;
        drive_src();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input logic [AW-2:0] n);
        num_words = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic pulse_start_w(input logic [AW-2:0] n);
        num_words_w = n;
        start_w     = 1'b1;
        tick();
        start_w     = 1'b0;
    endtask

    task automatic wait_nonseq(input bit w, input string tag);
        for (int i = 0; i < 40 && ((w ? HTRANS_w : HTRANS) != 2'b10); i++) tick();
        chk(tag, w ? HTRANS_w : HTRANS, 2'b10);
    endtask

    initial begin
        // Reset with arbitrary inputs
        HRESET = 1'b1; start = 1'b1; start_w = 1'b1;
        num_words = 13'd5; num_words_w = 13'd5;
        s_valid = 1'b1; s_data = 8'hA5; HREADY = 1'b1; HRESP = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hsel", HSELBRAM, 1'b0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_sready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_haddr", HADDR, 14'h0000);
        chk("rst_hsize", HSIZE, 2'b10);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_haddr_w", HADDR_w, 14'h3FFC);
        start = 1'b0; start_w = 1'b0; HRESP = 1'b0; s_valid = 1'b0;
        HRESET = 1'b0;
        tick();

        // Basic two-word load at full rate
        q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        qi = 0; drive_src();
        pulse_start(13'd2);
        chk("b_busy", busy, 1'b1);
        chk("b_sready", s_ready, 1'b1);
        ticks(4);
        chk("b_trans0", HTRANS, 2'b10);
        chk("b_addr0", HADDR, 14'h0000);
        chk("b_hsel0", HSELBRAM, 1'b1);
        chk("b_hwrite0", HWRITE, 1'b1);
        chk("b_sready_addr", s_ready, 1'b0);
        tick();
        chk("b_data0_trans", HTRANS, 2'b00);
        chk("b_data0_hsel", HSELBRAM, 1'b0);
        chk("b_wdata0", HWDATA, 32'h14131211);
        chk("b_sready_data", s_ready, 1'b1);
        ticks(4);
        chk("b_trans1", HTRANS, 2'b10);
        chk("b_addr1", HADDR, 14'h0004);
        tick();
        chk("b_wdata1", HWDATA, 32'h18171615);
        chk("b_notdone", done, 1'b0);
        tick();
        chk("b_done", done, 1'b1);
        chk("b_busy_end", busy, 1'b0);
        chk("b_bytes", qi, 8);

        // Stalls in address and data phase
        q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        qi = 0; drive_src();
        HREADY = 1'b0;
        pulse_start(13'd2);
        wait_nonseq(1'b0, "s_trans0");
        chk("s_addr0", HADDR, 14'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_astall_trans", HTRANS, 2'b10);
            chk("s_astall_addr", HADDR, 14'h0000);
            chk("s_astall_sready", s_ready, 1'b0);
        end
        HREADY = 1'b1;
        tick();
        chk("s_wdata0", HWDATA, 32'h24232221);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_dstall_wdata", HWDATA, 32'h24232221);
            chk("s_dstall_addr", HADDR, 14'h0000);
            chk("s_dstall_trans", HTRANS, 2'b00);
        end
        tick();
        chk("s_sready_full", s_ready, 1'b0);
        tick();
        chk("s_sready_hold", s_ready, 1'b0);
        chk("s_bytes", qi, 8);
        HREADY = 1'b1;
        tick();
        chk("s_trans1", HTRANS, 2'b10);
        chk("s_addr1", HADDR, 14'h0004);
        tick();
        chk("s_wdata1", HWDATA, 32'h28272625);
        tick();
        chk("s_done", done, 1'b1);

        // Error response on the first data phase
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        qi = 0; drive_src();
        pulse_start(13'd3);
        wait_nonseq(1'b0, "e_trans0");
        tick();
        chk("e_wdata0", HWDATA, 32'h34333231);
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        chk("e_error", error, 1'b1);
        chk("e_busy", busy, 1'b0);
        chk("e_trans", HTRANS, 2'b00);
        chk("e_sready", s_ready, 1'b0);
        HREADY = 1'b1;
        tick();
        chk("e_error2", error, 1'b1);
        HRESP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("e_sticky", error, 1'b1);
            chk("e_nobus", HTRANS, 2'b00);
        end
        chk("e_addr_held", HADDR, 14'h0000);
        q = '{8'h41, 8'h42, 8'h43, 8'h44};
        qi = 0; drive_src();
        pulse_start(13'd1);
        chk("e_clear", error, 1'b0);
        wait_nonseq(1'b0, "e_re_trans");
        chk("e_re_addr", HADDR, 14'h0000);
        tick();
        chk("e_re_wdata", HWDATA, 32'h44434241);
        tick();
        chk("e_re_done", done, 1'b1);

        // Address wrap on the high-base instance
        q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
        qi = 0; drive_src();
        pulse_start_w(13'd2);
        wait_nonseq(1'b1, "w_trans0");
        chk("w_addr0", HADDR_w, 14'h3FFC);
        tick();
        chk("w_wdata0", HWDATA_w, 32'h54535251);
        wait_nonseq(1'b1, "w_trans1");
        chk("w_addr1", HADDR_w, 14'h0000);
        tick();
        chk("w_wdata1", HWDATA_w, 32'h58575655);
        tick();
        chk("w_done", done_w, 1'b1);
        chk("w_other_idle", HTRANS, 2'b00);

        // Reset in the middle of a word
        q = '{8'h61, 8'h62};
        qi = 0; drive_src();
        pulse_start(13'd1);
        ticks(2);
        chk("r_busy", busy, 1'b1);
        chk("r_bytes", qi, 2);
        #2 HRESET = 1'b1;
        #1;
        chk("r_async_busy", busy, 1'b0);
        chk("r_async_sready", s_ready, 1'b0);
        chk("r_async_trans", HTRANS, 2'b00);
        chk("r_async_done", done, 1'b0);
        tick();
        HRESET = 1'b0;
        tick();

        // Zero-length load
        pulse_start(13'd0);
        chk("z_done", done, 1'b1);
        chk("z_busy", busy, 1'b0);
        chk("z_trans", HTRANS, 2'b00);
        ticks(2);
        chk("z_trans2", HTRANS, 2'b00);

        // Fresh word after the reset carries no stale lanes
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        qi = 0; drive_src();
        pulse_start(13'd1);
        wait_nonseq(1'b0, "r_trans");
        chk("r_addr", HADDR, 14'h0000);
        tick();
        chk("r_wdata", HWDATA, 32'hDDCCBBAA);
        tick();
        chk("r_done", done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
